// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - program store and PC that issue one opcode per cycle to the instruction decoder
module instruction_sequencer #(
  parameter int                     INSTR_WIDTH = 4,
  parameter int                     ADDR_WIDTH  = 4,
  parameter logic [INSTR_WIDTH-1:0] OP_LDI      = 4'hD,
  parameter logic [INSTR_WIDTH-1:0] OP_NOP      = 4'hC
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   RUN,
  input  logic                   RESET_INSTR,
  input  logic                   PROG_WE,
  input  logic [ADDR_WIDTH-1:0]  PROG_ADDR,
  input  logic [INSTR_WIDTH-1:0] PROG_DATA,
  output logic [INSTR_WIDTH-1:0] INSTRUCTION,
  output logic                   INSTR_VALID,
  output logic [INSTR_WIDTH-1:0] IMM,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic                   WRAPPED
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_FETCH, S_IMM} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] imm_q, imm_d;
  logic                   wrapped_q, wrapped_d;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [INSTR_WIDTH-1:0] word;

  // Program store: written on the clock edge, so a same-cycle fetch still sees the old word
  always_ff @(posedge CLK) begin
    if (PROG_WE) begin
      mem[PROG_ADDR] <= PROG_DATA;
    end
  end

  assign word = mem[pc_q];

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: restart beats pause, pause holds, otherwise LDI detours through IMM for one word
  always_comb begin
    state_d = state_q;
    if (RESET_INSTR) begin
      state_d = S_FETCH;
    end else if (RUN) begin
      case (state_q)
        S_FETCH: if (word == OP_LDI) state_d = S_IMM;
        S_IMM:   state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Output/datapath next values: anything not issued this edge is a NOP with valid low
  always_comb begin
    pc_d      = pc_q;
    instr_d   = OP_NOP;
    valid_d   = 1'b0;
    imm_d     = imm_q;
    wrapped_d = wrapped_q;
    if (RESET_INSTR) begin
      pc_d      = '0;
      wrapped_d = 1'b0;
    end else if (RUN) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
      if (&pc_q) begin
        wrapped_d = 1'b1;
      end
      case (state_q)
        S_FETCH: begin
          if (word != OP_LDI) begin
            instr_d = word;
            valid_d = 1'b1;
          end
        end
        S_IMM: begin
          imm_d   = word;
          instr_d = OP_LDI;
          valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and program counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q      <= '0;
      instr_q   <= OP_NOP;
      valid_q   <= 1'b0;
      imm_q     <= '0;
      wrapped_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      imm_q     <= imm_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = valid_q;
  assign IMM         = imm_q;
  assign PC          = pc_q;
  assign WRAPPED     = wrapped_q;

endmodule
